// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the 2->3->4 sequence checker.
package seq_chk_pkg;

    // Progress through the legal sequence: IDLE waits for 2, S2 for 3, S3 for 4.
    typedef enum logic [1:0] {
        IDLE,
        S2,
        S3
    } state_e;

    localparam logic [2:0] V_START = 3'd2;
    localparam logic [2:0] V_MID   = 3'd3;
    localparam logic [2:0] V_END   = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d, q_q;

    // Next count: step on inc unless already at the top value.
    always_comb begin
        q_d = q_q;
        if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_checker_2to4.sv
// Monitor for the 2->3->4 counter stage: pulses on completed sequences and on
// out-of-order values, with saturating tallies of both.
// Optional build macro SEQ_CHK_STICKY_EN adds err_clr / err_sticky.
module seq_checker_2to4
    import seq_chk_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       in_val,
    output logic [2:0]       exp_val,
    output logic             seq_done,
    output logic             err,
    output logic [CNT_W-1:0] seq_count,
    output logic [CNT_W-1:0] err_count
`ifdef SEQ_CHK_STICKY_EN
    ,
    input  logic             err_clr,
    output logic             err_sticky
`endif
);

    state_e state_d, state_q;
    logic   seq_done_d, seq_done_q;
    logic   err_d, err_q;

    // Next state and pulse decode; nothing moves on unqualified cycles.
    always_comb begin
        state_d    = state_q;
        seq_done_d = 1'b0;
        err_d      = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    // Resynchronise silently until a start value shows up.
                    if (in_val == V_START) begin
                        state_d = S2;
                    end
                end
                S2: begin
                    if (in_val == V_MID) begin
                        state_d = S3;
                    end else begin
                        err_d   = 1'b1;
                        state_d = (in_val == V_START) ? S2 : IDLE;
                    end
                end
                S3: begin
                    if (in_val == V_END) begin
                        state_d    = IDLE;
                        seq_done_d = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = (in_val == V_START) ? S2 : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state and registered pulses; reset drops any partial sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_done_q <= seq_done_d;
            err_q      <= err_d;
        end
    end

    // Expected next value decoded from the state register.
    always_comb begin
        unique case (state_q)
            IDLE:    exp_val = V_START;
            S2:      exp_val = V_MID;
            S3:      exp_val = V_END;
            default: exp_val = V_START;
        endcase
    end

    assign seq_done = seq_done_q;
    assign err      = err_q;

    // Counters take the unregistered pulse so they update on the same edge.
    sat_counter #(
        .W (CNT_W)
    ) u_seq_cnt (
        .clk (clk),
        .rst (rst),
        .inc (seq_done_d),
        .q   (seq_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_d),
        .q   (err_count)
    );

`ifdef SEQ_CHK_STICKY_EN
    logic err_sticky_d, err_sticky_q;

    // Sticky error flag; a new error beats a simultaneous clear.
    always_comb begin
        err_sticky_d = err_sticky_q;
        if (err_d) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_seq_checker_2to4.sv
// Bench for seq_checker_2to4: directed plan steps plus random traffic, checked
// against a progress-counter model of the 2,3,4 sequence rules.
module tb_seq_checker_2to4;

    localparam int unsigned CNT_W = 2;
    localparam int          MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [2:0]       in_val;
    logic [2:0]       exp_val;
    logic             seq_done;
    logic             err;
    logic [CNT_W-1:0] seq_count;
    logic [CNT_W-1:0] err_count;
`ifdef SEQ_CHK_STICKY_EN
    logic             err_clr;
    logic             err_sticky;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: prog = number of sequence values matched so far (0..2).
    int   prog;
    int   m_seq;
    int   m_err;
    logic m_done;
    logic m_errp;
    logic m_sticky;

    always #5 clk = ~clk;

    seq_checker_2to4 #(
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_val     (in_val),
        .exp_val    (exp_val),
        .seq_done   (seq_done),
        .err        (err),
        .seq_count  (seq_count),
        .err_count  (err_count)
`ifdef SEQ_CHK_STICKY_EN
        ,
        .err_clr    (err_clr),
        .err_sticky (err_sticky)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check all outputs.
    task automatic step(input logic v, input logic [2:0] val, input logic r, input logic clr);
        rst      = r;
        in_valid = v;
        in_val   = val;
`ifdef SEQ_CHK_STICKY_EN
        err_clr  = clr;
`endif
        @(posedge clk);
        if (r) begin
            prog = 0; m_seq = 0; m_err = 0;
            m_done = 1'b0; m_errp = 1'b0; m_sticky = 1'b0;
        end else begin
            m_done = 1'b0;
            m_errp = 1'b0;
            if (v) begin
                if (int'(val) == 2 + prog) begin
                    prog++;
                    if (prog == 3) begin
                        prog   = 0;
                        m_done = 1'b1;
                    end
                end else if (prog != 0) begin
                    m_errp = 1'b1;
                    prog   = (val == 3'd2) ? 1 : 0;
                end
            end
            if (m_done && m_seq < MAXC) m_seq++;
            if (m_errp && m_err < MAXC) m_err++;
            if (m_errp) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
        end
        #1;
        check("exp_val", 32'(exp_val), 32'(2 + prog));
        check("seq_done", 32'(seq_done), 32'(m_done));
        check("err", 32'(err), 32'(m_errp));
        check("seq_count", 32'(seq_count), 32'(m_seq));
        check("err_count", 32'(err_count), 32'(m_err));
`ifdef SEQ_CHK_STICKY_EN
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
`endif
    endtask

    task automatic feed(input logic [2:0] val);
        step(1'b1, val, 1'b0, 1'b0);
    endtask

    task automatic reset2();
        step(1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 3'd3, 1'b1, 1'b0);
    endtask

    initial begin
        logic [2:0] clean [6];
        logic [2:0] recov [6];
        logic [2:0] rest2 [4];
        clean = '{3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
        recov = '{3'd2, 3'd3, 3'd5, 3'd2, 3'd3, 3'd4};
        rest2 = '{3'd2, 3'd2, 3'd3, 3'd4};
        prog = 0; m_seq = 0; m_err = 0;
        m_done = 1'b0; m_errp = 1'b0; m_sticky = 1'b0;

        // Reset held with a valid non-start value on the bus.
        reset2();

        // Two clean sequences.
        foreach (clean[i]) feed(clean[i]);
        check("clean_seq_count", 32'(seq_count), 32'd2);
        check("clean_err_count", 32'(err_count), 32'd0);

        // Error then recovery.
        reset2();
        foreach (recov[i]) feed(recov[i]);
        check("recov_err_count", 32'(err_count), 32'd1);
        check("recov_seq_count", 32'(seq_count), 32'd1);

        // Restart on a repeated 2.
        reset2();
        foreach (rest2[i]) feed(rest2[i]);
        check("restart_err_count", 32'(err_count), 32'd1);
        check("restart_seq_count", 32'(seq_count), 32'd1);

        // Gap in valid holds state.
        reset2();
        feed(3'd2);
        repeat (3) step(1'b0, 3'd5, 1'b0, 1'b0);
        feed(3'd3);
        feed(3'd4);
        check("gap_seq_count", 32'(seq_count), 32'd1);

        // Reset mid-sequence discards progress without an error.
        reset2();
        feed(3'd2);
        feed(3'd3);
        step(1'b1, 3'd4, 1'b1, 1'b0);
        feed(3'd4);
        check("midrst_seq_count", 32'(seq_count), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);

        // Saturation of both counters; pulses keep firing at the top.
        reset2();
        repeat (5) begin
            feed(3'd2); feed(3'd3); feed(3'd4);
        end
        check("sat_seq_count", 32'(seq_count), 32'(MAXC));
        repeat (5) begin
            feed(3'd2); feed(3'd0);
        end
        check("sat_err_count", 32'(err_count), 32'(MAXC));

        // Sticky set, clear, and clear racing a new error.
        reset2();
        feed(3'd2);
        feed(3'd6);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0);
        feed(3'd2);
        step(1'b1, 3'd7, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0);

        // Random traffic biased toward the legal values.
        reset2();
        for (int n = 0; n < 400; n++) begin
            logic       v;
            logic [2:0] val;
            logic       r;
            logic       c;
            v   = ($urandom_range(0, 9) != 0);
            val = ($urandom_range(0, 3) != 0) ? 3'(2 + $urandom_range(0, 2))
                                               : 3'($urandom_range(0, 7));
            r   = ($urandom_range(0, 59) == 0);
            c   = ($urandom_range(0, 7) == 0);
            step(v, val, r, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
